seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 17 +
 rtl/cond_sub.sv | 26 ++
 rtl/seq_divider.sv | 121 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-bit full-adder cell, returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/cond_sub.sv
// Ripple subtractor a - b built from full-adder cells; borrow=1 when a < b.
module cond_sub
    import div_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0]   carry;
    logic [N-1:0] b_inv;

    // Two's-complement subtraction: a + ~b + 1, borrow is the inverted carry out.
    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign {carry[i+1], diff[i]} = full_add(a[i], b_inv[i], carry[i]);
    end

    assign borrow = ~carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock in CALC.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // One restoring step: shift {rem,quo} left, trial-subtract, restore on borrow.
    assign shift_rem = {rem[WIDTH-1:0], quo[WIDTH-1]};

    cond_sub #(.N(WIDTH + 1)) u_sub (
        .a      (shift_rem),
        .b      ({1'b0, dsr}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign step_rem = borrow ? shift_rem : diff;
    assign step_quo = {quo[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (divisor == '0) ? DONE : CALC;
            CALC:    if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered, so they are derived from the upcoming state.
    always_comb begin
        busy_d = (next_state != IDLE);
        done_d = (next_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dsr <= divisor;
                        quo <= dividend;
                        rem <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    cnt <= cnt + 1'b1;
                    // Final step result goes straight to the outputs on the edge into DONE.
                    if (cnt == LAST) begin
                        quotient    <= step_quo;
                        remainder   <= step_rem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
